ahb_lite_sram_slave: RTL and testbench
======================================

// Module: ahb_lite_sram_slave
// PURPOSE
//  AHB-lite responder: single-port on-chip SRAM in the SoC address map, answering the processor-side AHB-lite master.
//  Little-endian byte/half/word accesses; WAIT_STATES data-phase wait cycles; optional two-cycle ERROR response.
//  Burst addresses come from the master; each beat is handled as an individual pipelined transfer.
// PARAMETERS
//  MEM_BYTES    4096  SRAM size in bytes; power of 2, >= 4; AW = $clog2(MEM_BYTES)
//  WAIT_STATES  0     data-phase wait cycles per accepted transfer, 0..7
// PORTS
//  HCLK       in   1   bus clock, rising edge
//  HRESETn    in   1   reset, asynchronous, active-low
//  HSEL       in   1   slave select from address decoder
//  HADDR      in   32  byte address (address phase)
//  HWRITE     in   1   1 = write, 0 = read
//  HSIZE      in   2   00 byte, 01 half, 10 word, 11 unsupported
//  HTRANS     in   2   00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  HREADY     in   1   bus-level ready (previous transfer completed)
//  HWDATA     in   32  write data (data phase)
//  HRDATA     out  32  read data (data phase)
//  HREADYOUT  out  1   this slave's data-phase ready
//  HRESP      out  1   0 OKAY, 1 ERROR
// BEHAVIOUR
//  Reset: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=ST_IDLE, wait counter=0, captured addr/ctrl=0. SRAM contents not reset.
//  Accept: HSEL & HREADY & HTRANS[1] at a rising edge -> register HADDR[AW-1:0], HWRITE, HSIZE, error flag; data phase starts next cycle.
//  HSEL with IDLE/BUSY, or HSEL low: no access; next cycle zero-wait OKAY (ST_IDLE).
//  FSM states: ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2.
//   ST_IDLE: HREADYOUT=1. On accept: err -> ST_ERR1; WAIT_STATES>0 -> ST_WAIT with cnt=WAIT_STATES-1; else ST_DATA.
//   ST_WAIT: HREADYOUT=0; cnt==0 -> ST_DATA, else cnt-1. Nothing accepted (HREADY low).
//   ST_DATA: HREADYOUT=1, HRESP=0. Write commits at end of cycle using HWDATA. Read: HRDATA=mem word at captured addr.
//            A new accept in the same cycle is pipelined (same rules as ST_IDLE). Otherwise -> ST_IDLE.
//   ST_ERR1: HREADYOUT=0, HRESP=1 -> ST_ERR2.
//   ST_ERR2: HREADYOUT=1, HRESP=1. An accept here is handled like ST_IDLE. Otherwise -> ST_IDLE.
//  Read latency: HRDATA valid WAIT_STATES+1 cycles after the address-phase edge. HRDATA=0 when not a completing read.
//  Byte lanes: byte -> lane addr[1:0]; half -> lanes {addr[1],1'b0}+:2; word -> lanes 0..3. Only enabled lanes are written.
//  Back-to-back write then read at the same address returns the new data, because the write commits before the read data phase.
//  Reset mid-transfer: a pending write is dropped. The FSM returns to ST_IDLE immediately (asynchronous).
// CONFIGURATION
//  AHB_SRAM_ERR_EN defined: err = HADDR[31:AW]!=0 | HSIZE==11 | (half & addr[0]) | (word & addr[1:0]!=0).
//   An error gives the ERR1/ERR2 sequence with no wait states. Writes are suppressed; HRDATA=0.
//  Undefined: no ERROR response; HRESP is tied 0; normal wait timing for every access.
//   Out-of-range: reads return 0, writes dropped. Misaligned: low address bits are masked to the access size.
//   HSIZE==11 is treated as a word access.
// STRUCTURE
//  ahb_pkg (shared): htrans_t {IDLE,BUSY,NONSEQ,SEQ}, hsize_t codes, HRESP_OKAY/HRESP_ERROR, ahb_slv_state_t.
//  Sub-module ahb_sram_mem: MEM_BYTES/4 x 32 array, 4-bit byte-enable synchronous write, combinational read.
//  The top level holds the address/control capture, wait counter, FSM and lane decode.
// TESTING
//  1 Reset asserted -> HREADYOUT=1, HRESP=0, HRDATA=0; deassert with IDLE on bus -> outputs unchanged.
//  2 WAIT_STATES=0: write 0xDEADBEEF @0x10 pipelined into read @0x10 -> HRDATA=0xDEADBEEF next cycle, HREADYOUT never 0.
//  3 Word 0 @0x20, byte 0xAA @0x21, half 0x5566 @0x22 -> read @0x20 returns 0x5566AA00.
//  4 WAIT_STATES=2: NONSEQ read @0x40 -> HREADYOUT 0,0,1; next held address accepted only on the third cycle.
//  5 ERR_EN, MEM_BYTES=4096: read @0x2000 -> (HREADYOUT,HRESP)=(0,1),(1,1); word write @0x13 -> mem unchanged.
//    Without ERR_EN: read @0x2000 -> OKAY, HRDATA=0.
//  6 WAIT_STATES=3: reset in ST_WAIT during write 0x12345678 @0x8 -> old data persists. BUSY with HSEL -> zero-wait OKAY, no access.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-lite types: transfer/size encodings, response codes and slave FSM states.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        HSIZE_BYTE = 2'b00,
        HSIZE_HALF = 2'b01,
        HSIZE_WORD = 2'b10,
        HSIZE_RSVD = 2'b11
    } hsize_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } ahb_slv_state_t;

    // Little-endian byte-lane enables; the reserved size is handled as a word.
    function automatic logic [3:0] lane_be(input hsize_t sz, input logic [1:0] a);
        case (sz)
            HSIZE_BYTE: lane_be = 4'b0001 << a;
            HSIZE_HALF: lane_be = a[1] ? 4'b1100 : 4'b0011;
            default:    lane_be = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// Word-organised SRAM: byte-enable synchronous write, combinational read. Contents are not reset.
module ahb_sram_mem #(
    parameter int WORDS = 1024,
    parameter int IW    = 10
) (
    input  logic          HCLK,
    input  logic [3:0]    we_i,
    input  logic [IW-1:0] idx_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [WORDS];

    always_ff @(posedge HCLK) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-lite SRAM responder with configurable data-phase wait states.
// Define AHB_SRAM_ERR_EN to answer out-of-range/misaligned/unsupported accesses with an ERROR response.
module ahb_lite_sram_slave
    import ahb_pkg::*;
#(
    parameter int MEM_BYTES   = 4096,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [1:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int AW = $clog2(MEM_BYTES);
    localparam int IW = (AW > 2) ? AW - 2 : 1;
    localparam logic [2:0] WS = 3'(WAIT_STATES);

    ahb_slv_state_t state_q, state_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           write_q, write_d;
    hsize_t         size_q, size_d;
    logic           oor_q, oor_d;

    logic        accept, oor, err, rdy;
    logic [3:0]  we;
    logic [31:0] rdata;

    assign accept = HSEL && HREADY &&
                    (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
    assign oor    = (HADDR >> AW) != 32'd0;

`ifdef AHB_SRAM_ERR_EN
    assign err = oor || (HSIZE == HSIZE_RSVD) ||
                 (HSIZE == HSIZE_HALF && HADDR[0]) ||
                 (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00);
    assign HRESP = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
`else
    assign err   = 1'b0;
    assign HRESP = HRESP_OKAY;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        oor_d   = oor_q;
        rdy     = 1'b1;
        case (state_q)
            ST_WAIT: begin
                rdy = 1'b0;
                if (cnt_q == 3'd0) state_d = ST_DATA;
                else               cnt_d   = cnt_q - 3'd1;
            end
            ST_ERR1: begin
                rdy     = 1'b0;
                state_d = ST_ERR2;
            end
            default: ;
        endcase
        // IDLE, DATA and ERR2 complete this cycle and can take the next address phase
        if (rdy) begin
            if (accept) begin
                addr_d  = HADDR[AW-1:0];
                write_d = HWRITE;
                size_d  = hsize_t'(HSIZE);
                oor_d   = oor;
                if (err) begin
                    state_d = ST_ERR1;
                end else if (WS != 3'd0) begin
                    state_d = ST_WAIT;
                    cnt_d   = WS - 3'd1;
                end else begin
                    state_d = ST_DATA;
                end
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= HSIZE_BYTE;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
            oor_q   <= oor_d;
        end
    end

    assign we = (state_q == ST_DATA && write_q && !oor_q) ? lane_be(size_q, addr_q[1:0]) : 4'b0000;

    ahb_sram_mem #(
        .WORDS (MEM_BYTES / 4),
        .IW    (IW)
    ) u_mem (
        .HCLK    (HCLK),
        .we_i    (we),
        .idx_i   (IW'(addr_q >> 2)),
        .wdata_i (HWDATA),
        .rdata_o (rdata)
    );

    assign HREADYOUT = rdy;
    assign HRDATA    = (state_q == ST_DATA && !write_q && !oor_q) ? rdata : 32'd0;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench: three slaves (0, 2 and 3 wait states) on a shared bus, each selected by its own HSEL.
module tb_ahb_lite_sram_slave;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [2:0]  hsel = '0;
    logic [31:0] haddr = '0, hwdata = '0;
    logic        hwrite = 1'b0;
    logic [1:0]  hsize = 2'b10, htrans = 2'b00;
    logic [2:0]  rdy, resp;
    logic [31:0] rdata [3];

    int n_chk = 0, n_err = 0;

    always #5 HCLK = ~HCLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ahb_lite_sram_slave #(
            .MEM_BYTES   (4096),
            .WAIT_STATES ((g == 0) ? 0 : (g == 1) ? 2 : 3)
        ) u_dut (
            .HCLK      (HCLK),
            .HRESETn   (HRESETn),
            .HSEL      (hsel[g]),
            .HADDR     (haddr),
            .HWRITE    (hwrite),
            .HSIZE     (hsize),
            .HTRANS    (htrans),
            .HREADY    (rdy[g]),
            .HWDATA    (hwdata),
            .HRDATA    (rdata[g]),
            .HREADYOUT (rdy[g]),
            .HRESP     (resp[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic idle_bus();
        hsel = '0; htrans = 2'b00; haddr = '0; hwrite = 1'b0; hsize = 2'b10;
    endtask

    task automatic addr_ph(input int k, input logic [31:0] a, input logic wr,
                           input logic [1:0] sz, input logic [1:0] tr);
        hsel = '0; hsel[k] = 1'b1; haddr = a; hwrite = wr; hsize = sz; htrans = tr;
    endtask

    // Single non-pipelined transfer; starts and ends just after a rising edge.
    task automatic xfer(input int k, input logic [31:0] a, input logic wr, input logic [1:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd, output int waits);
        addr_ph(k, a, wr, sz, 2'b10);
        @(posedge HCLK); #1;
        idle_bus();
        hwdata = wd;
        waits = 0;
        @(negedge HCLK);
        while (!rdy[k] && waits < 20) begin
            waits++;
            @(negedge HCLK);
        end
        rd = rdata[k];
        @(posedge HCLK); #1;
    endtask

    logic [31:0] rd;
    int          w;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state, then release with IDLE on the bus
        #2;
        for (int k = 0; k < 3; k++) begin
            chk("rst_rdy", 32'(rdy[k]), 32'd1);
            chk("rst_resp", 32'(resp[k]), 32'd0);
            chk("rst_rdata", rdata[k], 32'd0);
        end
        repeat (2) @(posedge HCLK);
        @(negedge HCLK); HRESETn = 1'b1;
        @(posedge HCLK); #1;
        @(negedge HCLK);
        chk("post_rst_rdy", 32'(rdy[0]), 32'd1);
        chk("post_rst_rdata", rdata[0], 32'd0);
        @(posedge HCLK); #1;

        // Zero-wait write pipelined into read of the same address
        addr_ph(0, 32'h10, 1'b1, 2'b10, 2'b10);
        @(posedge HCLK); #1;
        hwdata = 32'hDEADBEEF;
        addr_ph(0, 32'h10, 1'b0, 2'b10, 2'b10);
        @(negedge HCLK);
        chk("pipe_rdy_w", 32'(rdy[0]), 32'd1);
        @(posedge HCLK); #1;
        idle_bus();
        @(negedge HCLK);
        chk("pipe_rdy_r", 32'(rdy[0]), 32'd1);
        chk("pipe_rdata", rdata[0], 32'hDEADBEEF);
        @(posedge HCLK); #1;
        @(negedge HCLK);
        chk("pipe_rdata_idle", rdata[0], 32'd0);
        @(posedge HCLK); #1;

        // BUSY with HSEL: zero-wait OKAY and no write
        addr_ph(0, 32'h10, 1'b1, 2'b10, 2'b01);
        @(posedge HCLK); #1;
        idle_bus();
        hwdata = 32'hFFFFFFFF;
        @(negedge HCLK);
        chk("busy_rdy", 32'(rdy[0]), 32'd1);
        chk("busy_resp", 32'(resp[0]), 32'd0);
        chk("busy_rdata", rdata[0], 32'd0);
        @(posedge HCLK); #1;
        xfer(0, 32'h10, 1'b0, 2'b10, 32'h0, rd, w);
        chk("busy_nowrite", rd, 32'hDEADBEEF);

        // Byte lanes
        xfer(0, 32'h20, 1'b1, 2'b10, 32'h00000000, rd, w);
        xfer(0, 32'h21, 1'b1, 2'b00, 32'h0000AA00, rd, w);
        xfer(0, 32'h22, 1'b1, 2'b01, 32'h55660000, rd, w);
        xfer(0, 32'h20, 1'b0, 2'b10, 32'h0, rd, w);
        chk("lanes_word", rd, 32'h5566AA00);
        chk("lanes_waits", 32'(w), 32'd0);

        // Two wait states: address held through the wait is taken only on the third cycle
        xfer(1, 32'h40, 1'b1, 2'b10, 32'hA5A50040, rd, w);
        chk("ws2_wr_waits", 32'(w), 32'd2);
        xfer(1, 32'h44, 1'b1, 2'b10, 32'h5A5A0044, rd, w);
        addr_ph(1, 32'h40, 1'b0, 2'b10, 2'b10);
        @(posedge HCLK); #1;
        addr_ph(1, 32'h44, 1'b0, 2'b10, 2'b10);
        @(negedge HCLK); chk("ws2_rdy_c1", 32'(rdy[1]), 32'd0);
        @(negedge HCLK); chk("ws2_rdy_c2", 32'(rdy[1]), 32'd0);
        @(negedge HCLK); chk("ws2_rdy_c3", 32'(rdy[1]), 32'd1);
        chk("ws2_rdata0", rdata[1], 32'hA5A50040);
        @(posedge HCLK); #1;
        idle_bus();
        @(negedge HCLK); chk("ws2_rdy_c4", 32'(rdy[1]), 32'd0);
        chk("ws2_rdata_wait", rdata[1], 32'd0);
        @(negedge HCLK); chk("ws2_rdy_c5", 32'(rdy[1]), 32'd0);
        @(negedge HCLK); chk("ws2_rdy_c6", 32'(rdy[1]), 32'd1);
        chk("ws2_rdata1", rdata[1], 32'h5A5A0044);
        @(posedge HCLK); #1;

        // Out-of-range / misaligned / unsupported size
        xfer(0, 32'h0, 1'b1, 2'b10, 32'h0BADF00D, rd, w);
`ifdef AHB_SRAM_ERR_EN
        addr_ph(0, 32'h2000, 1'b0, 2'b10, 2'b10);
        @(posedge HCLK); #1;
        idle_bus();
        @(negedge HCLK);
        chk("err1_rdy", 32'(rdy[0]), 32'd0);
        chk("err1_resp", 32'(resp[0]), 32'd1);
        @(negedge HCLK);
        chk("err2_rdy", 32'(rdy[0]), 32'd1);
        chk("err2_resp", 32'(resp[0]), 32'd1);
        chk("err2_rdata", rdata[0], 32'd0);
        @(negedge HCLK);
        chk("err_done_resp", 32'(resp[0]), 32'd0);
        @(posedge HCLK); #1;
        xfer(0, 32'h13, 1'b1, 2'b10, 32'hCAFEF00D, rd, w);
        chk("err_wr_waits", 32'(w), 32'd1);
        xfer(0, 32'h10, 1'b0, 2'b10, 32'h0, rd, w);
        chk("err_wr_dropped", rd, 32'hDEADBEEF);
`else
        xfer(0, 32'h2000, 1'b0, 2'b10, 32'h0, rd, w);
        chk("oor_rdata", rd, 32'd0);
        chk("oor_waits", 32'(w), 32'd0);
        chk("oor_resp", 32'(resp[0]), 32'd0);
        xfer(0, 32'h2000, 1'b1, 2'b10, 32'h11111111, rd, w);
        xfer(0, 32'h0, 1'b0, 2'b10, 32'h0, rd, w);
        chk("oor_wr_dropped", rd, 32'h0BADF00D);
        xfer(0, 32'h13, 1'b1, 2'b10, 32'hCAFEF00D, rd, w);
        xfer(0, 32'h10, 1'b0, 2'b10, 32'h0, rd, w);
        chk("misalign_masked", rd, 32'hCAFEF00D);
        xfer(0, 32'h31, 1'b1, 2'b11, 32'h01020304, rd, w);
        xfer(0, 32'h30, 1'b0, 2'b10, 32'h0, rd, w);
        chk("size11_word", rd, 32'h01020304);
`endif

        // Reset during the wait of a write: write is lost, FSM back to idle at once
        xfer(2, 32'h8, 1'b1, 2'b10, 32'h11112222, rd, w);
        chk("ws3_wr_waits", 32'(w), 32'd3);
        addr_ph(2, 32'h8, 1'b1, 2'b10, 2'b10);
        @(posedge HCLK); #1;
        idle_bus();
        hwdata = 32'h12345678;
        @(negedge HCLK);
        chk("ws3_rdy_wait", 32'(rdy[2]), 32'd0);
        HRESETn = 1'b0;
        #1;
        chk("midrst_rdy", 32'(rdy[2]), 32'd1);
        chk("midrst_resp", 32'(resp[2]), 32'd0);
        chk("midrst_rdata", rdata[2], 32'd0);
        @(negedge HCLK); HRESETn = 1'b1;
        @(posedge HCLK); #1;
        xfer(2, 32'h8, 1'b0, 2'b10, 32'h0, rd, w);
        chk("midrst_old_data", rd, 32'h11112222);
        chk("ws3_rd_waits", 32'(w), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
